// File: rtl/biu_arbiter.sv
`timescale 1ns/1ps
// biu_arbiter: shares one BIU slave port among NUM_MASTERS masters.
// Each master has a one-deep request buffer; grants rotate round-robin.
module biu_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                              clk,
   input  logic                              n_rst,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
   input  logic [NUM_MASTERS-1:0]            m_rnw,
   input  logic [NUM_MASTERS-1:0]            m_en,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
   output logic [NUM_MASTERS-1:0]            m_data_valid,
   output logic [NUM_MASTERS-1:0]            m_busy,
   output logic [ADDR_WIDTH-1:0]             s_address,
   output logic [DATA_WIDTH-1:0]             s_data_out,
   output logic                              s_rnw,
   output logic                              s_en,
   input  logic [DATA_WIDTH-1:0]             s_data_in,
   input  logic                              s_data_valid
);
   localparam int IW = $clog2(NUM_MASTERS);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   state_t                 state_r;
   state_t                 state_next_s;
   logic [NUM_MASTERS-1:0] pend_r;
   logic [ADDR_WIDTH-1:0]  addr_r  [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  wdata_r [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] rnw_r;
   logic [IW-1:0]          last_r;
   logic [IW-1:0]          grant_r;
   logic [IW-1:0]          winner_s;
   logic                   issue_s;
   logic                   complete_s;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int step);
      return IW'((int'(base) + step) % NUM_MASTERS);
   endfunction

   assign m_busy = pend_r;

   // Round-robin search; scanning from the far end lets the nearest pending master win.
   always_comb begin
      winner_s = last_r;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         winner_s = pend_r[rr_idx(last_r, k)] ? rr_idx(last_r, k) : winner_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = (|pend_r) ? ISSUE : IDLE;
         ISSUE:   state_next_s = s_data_valid ? IDLE : WAIT;
         WAIT:    state_next_s = s_data_valid ? IDLE : WAIT;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM decode: grant in IDLE, completion only while a transaction is outstanding.
   always_comb begin
      issue_s    = 1'b0;
      complete_s = 1'b0;
      case (state_r)
         IDLE:    issue_s    = |pend_r;
         ISSUE:   complete_s = s_data_valid;
         WAIT:    complete_s = s_data_valid;
         default: begin
            issue_s    = 1'b0;
            complete_s = 1'b0;
         end
      endcase
   end

   // Request buffers; a strobe while pending is dropped, completion frees the slot.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_r <= '0;
         rnw_r  <= '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_r[i]  <= '0;
            wdata_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (complete_s && (grant_r == IW'(i))) begin
               pend_r[i] <= 1'b0;
            end else if (m_en[i] && !pend_r[i]) begin
               pend_r[i]  <= 1'b1;
               addr_r[i]  <= m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_r[i] <= m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
               rnw_r[i]   <= m_rnw[i];
            end
         end
      end
   end

   // Grant register and slave-side request outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         last_r     <= IW'(NUM_MASTERS - 1);
         grant_r    <= '0;
         s_en       <= 1'b0;
         s_address  <= '0;
         s_data_out <= '0;
         s_rnw      <= 1'b0;
      end else begin
         s_en <= issue_s;
         if (issue_s) begin
            grant_r    <= winner_s;
            last_r     <= winner_s;
            s_address  <= addr_r[winner_s];
            s_data_out <= wdata_r[winner_s];
            s_rnw      <= rnw_r[winner_s];
         end
      end
   end

   // Response routing back to the granted master.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_data_valid <= '0;
         m_data_in    <= '0;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            m_data_valid[i] <= complete_s && (grant_r == IW'(i));
            if (complete_s && (grant_r == IW'(i))) begin
               m_data_in[i*DATA_WIDTH +: DATA_WIDTH] <= s_data_in;
            end
         end
      end
   end
endmodule

// File: tb/tb_biu_arbiter.sv
`timescale 1ns/1ps
// tb_biu_arbiter: directed and randomized stimulus against a transaction-level
// reference of the arbiter (pending buffers, owner of the slave, rotating pointer).
module tb_biu_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            n_rst;
   logic [N*AW-1:0] m_address;
   logic [N*DW-1:0] m_data_out;
   logic [N-1:0]    m_rnw;
   logic [N-1:0]    m_en;
   logic [N*DW-1:0] m_data_in;
   logic [N-1:0]    m_data_valid;
   logic [N-1:0]    m_busy;
   logic [AW-1:0]   s_address;
   logic [DW-1:0]   s_data_out;
   logic            s_rnw;
   logic            s_en;
   logic [DW-1:0]   s_data_in;
   logic            s_data_valid;

   biu_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .n_rst(n_rst),
      .m_address(m_address), .m_data_out(m_data_out), .m_rnw(m_rnw), .m_en(m_en),
      .m_data_in(m_data_in), .m_data_valid(m_data_valid), .m_busy(m_busy),
      .s_address(s_address), .s_data_out(s_data_out), .s_rnw(s_rnw), .s_en(s_en),
      .s_data_in(s_data_in), .s_data_valid(s_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference state
   logic [N-1:0]    mp;
   logic [AW-1:0]   ma [N];
   logic [DW-1:0]   md [N];
   logic            mr [N];
   int              m_last, m_owner;
   logic            m_fresh;
   logic [N*DW-1:0] e_din;
   logic [N-1:0]    e_dv;
   logic [AW-1:0]   e_sa;
   logic [DW-1:0]   e_sd;
   logic            e_sr;

   // stimulus / observation
   int            checks, errors, cyc, wcnt, slave_lat;
   bit            rand_mode, spurious;
   logic [DW-1:0] slave_data;
   int            dv_cnt [N];
   int            sen_q[$];
   logic [AW-1:0] sa_q[$];
   logic [AW-1:0] tmp_a;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      mp = '0; m_last = N - 1; m_owner = -1; m_fresh = 1'b0;
      for (int i = 0; i < N; i++) begin ma[i] = '0; md[i] = '0; mr[i] = 1'b0; end
      e_din = '0; e_dv = '0; e_sa = '0; e_sd = '0; e_sr = 1'b0;
   endtask

   // One clock edge of the reference: capture, complete, or grant.
   task automatic model_edge();
      logic [N-1:0] pre;
      bit done;
      pre  = mp;
      done = (m_owner >= 0) && (s_data_valid === 1'b1);
      e_dv = '0;
      for (int i = 0; i < N; i++) begin
         if (m_en[i] && !pre[i]) begin
            mp[i] = 1'b1; ma[i] = m_address[i*AW +: AW];
            md[i] = m_data_out[i*DW +: DW]; mr[i] = m_rnw[i];
         end
      end
      if (done) begin
         e_dv[m_owner] = 1'b1;
         e_din[m_owner*DW +: DW] = s_data_in;
         mp[m_owner] = 1'b0;
         m_owner = -1; m_fresh = 1'b0;
      end else if (m_owner >= 0) begin
         m_fresh = 1'b0;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (pre[j] && m_owner < 0) begin
               m_owner = j; m_last = j; m_fresh = 1'b1;
               e_sa = ma[j]; e_sd = md[j]; e_sr = mr[j];
            end
         end
      end
   endtask

   task automatic check_all();
      chk("m_data_in", m_data_in, e_din);
      chk("m_data_valid", m_data_valid, e_dv);
      chk("m_busy", m_busy, mp);
      chk("s_en", s_en, m_fresh);
      chk("s_address", s_address, e_sa);
      chk("s_data_out", s_data_out, e_sd);
      chk("s_rnw", s_rnw, e_sr);
   endtask

   task automatic strobe(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
      m_en[i] = 1'b1; m_address[i*AW +: AW] = a; m_data_out[i*DW +: DW] = d; m_rnw[i] = r;
   endtask

   task automatic clear_obs();
      cyc = 0; sen_q.delete(); sa_q.delete();
      for (int i = 0; i < N; i++) dv_cnt[i] = 0;
   endtask

   // Advance one cycle, compare every output, then drive the next cycle's inputs.
   task automatic tick();
      @(posedge clk);
      if (n_rst === 1'b0) model_reset(); else model_edge();
      #1;
      cyc++;
      check_all();
      for (int i = 0; i < N; i++) if (m_data_valid[i] === 1'b1) dv_cnt[i]++;
      if (s_en === 1'b1) begin sen_q.push_back(cyc); sa_q.push_back(s_address); end
      m_en = '0;
      if (rand_mode) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) strobe(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
         spurious  = ($urandom_range(0, 3) == 0);
         s_data_in = $urandom;
      end else begin
         s_data_in = slave_data;
      end
      if (m_fresh) wcnt = rand_mode ? int'($urandom_range(0, 3)) : slave_lat;
      if (m_owner >= 0) begin
         if (wcnt == 0) s_data_valid = 1'b1;
         else begin s_data_valid = 1'b0; wcnt--; end
      end else begin
         s_data_valid = spurious;
      end
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick(); tick();
      n_rst = 1'b1;
      tick();
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; wcnt = 0; slave_lat = 0;
      rand_mode = 1'b0; spurious = 1'b0; slave_data = '0;
      m_address = '0; m_data_out = '0; m_rnw = '0; m_en = '0;
      s_data_in = '0; s_data_valid = 1'b0; n_rst = 1'b1;
      model_reset();
      #2 n_rst = 1'b0;
      #1 check_all();
      tick(); tick();
      n_rst = 1'b1;
      tick();

      // single read, two slave wait cycles
      clear_obs(); slave_lat = 2; slave_data = 32'hDEADBEEF;
      strobe(0, 32'h0000_0100, 32'h0, 1'b1);
      repeat (6) tick();
      chk("read_sen_cycle", sen_q.size() > 0 ? sen_q[0] : -1, 32'd2);
      chk("read_dv_count", dv_cnt[0], 32'd1);

      // write path, zero-wait slave
      clear_obs(); slave_lat = 0; slave_data = 32'hCAFE_0002;
      strobe(2, 32'h0000_0040, 32'h0000_1234, 1'b0);
      repeat (5) tick();
      chk("write_sen_cycle", sen_q.size() > 0 ? sen_q[0] : -1, 32'd2);
      chk("write_dv_count", dv_cnt[2], 32'd1);
      chk("write_other_dv", dv_cnt[0] + dv_cnt[1] + dv_cnt[3], 32'd0);

      // fairness: all four strobe together, slave answers one cycle after s_en
      do_reset();
      clear_obs(); slave_lat = 1; slave_data = 32'h5555_AAAA;
      for (int i = 0; i < N; i++) strobe(i, AW'((i + 1) << 12), DW'(i), 1'b1);
      repeat (13) tick();
      chk("fair_grants", sen_q.size(), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("fair_sen_cycle", sen_q[k], 32'(2 + 3 * k));
         tmp_a = sa_q[k];
         chk("fair_order", tmp_a[15:12], 32'(k + 1));
      end

      // master 0 keeps strobing: it must wait behind 1,2,3
      clear_obs();
      for (int i = 0; i < N; i++) strobe(i, AW'((i + 1) << 12), DW'(i + 8), 1'b1);
      for (int t = 0; t < 24; t++) begin
         tick();
         strobe(0, 32'h0000_1000 + AW'(t), DW'(t), 1'b1);
      end
      m_en = '0;
      for (int k = 0; k < 5; k++) begin
         tmp_a = sa_q[k];
         chk("rr_order", tmp_a[15:12], (k == 4) ? 32'd1 : 32'(k + 1));
      end

      // busy drop: the second strobe is ignored
      do_reset();
      clear_obs(); slave_lat = 2; slave_data = 32'h0BAD_F00D;
      strobe(1, 32'h0000_0010, 32'h1, 1'b1);
      tick();
      strobe(1, 32'h0000_0020, 32'h2, 1'b1);
      repeat (8) tick();
      chk("drop_issues", sa_q.size(), 32'd1);
      chk("drop_addr", sa_q[0], 32'h0000_0010);
      chk("drop_dv_count", dv_cnt[1], 32'd1);

      // reset during WAIT with masters 0 and 3 pending, then late s_data_valid
      clear_obs(); slave_lat = 20; slave_data = 32'h1111_2222;
      strobe(0, 32'h0000_0500, 32'h5, 1'b1);
      strobe(3, 32'h0000_0530, 32'h6, 1'b0);
      repeat (4) tick();
      n_rst = 1'b0; s_data_valid = 1'b0;
      #1 model_reset(); check_all();
      tick(); tick();
      n_rst = 1'b1;
      clear_obs(); spurious = 1'b1; s_data_valid = 1'b1;
      repeat (3) tick();
      spurious = 1'b0;
      chk("late_valid_dv", dv_cnt[0] + dv_cnt[1] + dv_cnt[2] + dv_cnt[3], 32'd0);
      chk("late_valid_sen", sen_q.size(), 32'd0);
      clear_obs(); slave_lat = 1; slave_data = 32'h7777_0001;
      strobe(1, 32'h0000_0700, 32'h7, 1'b1);
      repeat (6) tick();
      chk("post_reset_sen", sen_q.size() > 0 ? sen_q[0] : -1, 32'd2);
      chk("post_reset_dv", dv_cnt[1], 32'd1);

      // spurious s_data_valid while idle
      clear_obs(); spurious = 1'b1; slave_data = 32'h9999_9999; s_data_valid = 1'b1;
      repeat (4) tick();
      spurious = 1'b0;
      chk("idle_valid_dv", dv_cnt[0] + dv_cnt[1] + dv_cnt[2] + dv_cnt[3], 32'd0);

      // randomized traffic, then drain
      clear_obs(); rand_mode = 1'b1;
      repeat (600) tick();
      rand_mode = 1'b0; spurious = 1'b0;
      repeat (30) tick();
      chk("drain_busy", m_busy, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
